writeback_regfile: RTL and testbench

//  Final pipeline stage: consumes Execute's registered result bundle (outbubble, write_reg/num/data,

---
 rtl/writeback_regfile_pkg.sv | 34 +++
 rtl/writeback_regfile_if.sv | 35 +++
 rtl/writeback_regfile_regfile.sv | 35 +++
 rtl/writeback_regfile.sv | 109 ++++++++++
 tb/tb_writeback_regfile.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/writeback_regfile_pkg.sv
// rtl/writeback_regfile_pkg.sv - shared constants for the writeback stage (PSR bits, PC register, reset CPSR)
package writeback_regfile_pkg;

  // Processor mode field encoding (CPSR[4:0])
  localparam logic [4:0] MODE_USR = 5'b10000;
  localparam logic [4:0] MODE_SVC = 5'b10011;

  // CPSR control bit positions
  localparam int CPSR_T_BIT = 5;
  localparam int CPSR_F_BIT = 6;
  localparam int CPSR_I_BIT = 7;

  // Register number whose commit redirects Fetch
  localparam logic [3:0] PC_REG_NUM = 4'd15;

  // Build a CPSR value from mode and interrupt-disable flags
  function automatic logic [31:0] make_cpsr(input logic [4:0] mode, input logic irq_off,
                                            input logic fiq_off);
    logic [31:0] v;
    v             = 32'h0;
    v[4:0]        = mode;
    v[CPSR_T_BIT] = 1'b0;
    v[CPSR_F_BIT] = fiq_off;
    v[CPSR_I_BIT] = irq_off;
    return v;
  endfunction

  // Reset state: supervisor mode with IRQ and FIQ masked (32'h000000D3)
  localparam logic [31:0] CPSR_RESET = make_cpsr(MODE_SVC, 1'b1, 1'b1);

  // Mode used when a caller asks for an unprivileged PSR template
  localparam logic [31:0] CPSR_USER = make_cpsr(MODE_USR, 1'b0, 1'b0);

endpackage

// File: rtl/writeback_regfile_if.sv
// rtl/writeback_regfile_if.sv - Execute result bundle and Issue read-port bus into the writeback stage
interface writeback_regfile_if #(
  parameter int DATA_W = 32
) ();

  // Result bundle from Execute
  logic              stall;
  logic              inbubble;
  logic              write_reg;
  logic [3:0]        write_num;
  logic [DATA_W-1:0] write_data;
  logic [DATA_W-1:0] incpsr;
  logic [DATA_W-1:0] inspsr;

  // Operand read ports serving Issue (Rn, Rm, Rs)
  logic [3:0]        rd0_num;
  logic [3:0]        rd1_num;
  logic [3:0]        rd2_num;
  logic [DATA_W-1:0] rd0_data;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;

  modport master (
    output stall, inbubble, write_reg, write_num, write_data, incpsr, inspsr,
    output rd0_num, rd1_num, rd2_num,
    input  rd0_data, rd1_data, rd2_data
  );

  modport slave (
    input  stall, inbubble, write_reg, write_num, write_data, incpsr, inspsr,
    input  rd0_num, rd1_num, rd2_num,
    output rd0_data, rd1_data, rd2_data
  );

endinterface

// File: rtl/writeback_regfile_regfile.sv
// rtl/writeback_regfile_regfile.sv - regfile_16x32: 16-entry register array, 1 write port, 3 async read ports
module regfile_16x32 #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              Nrst,
  input  logic              i_we,
  input  logic [3:0]        i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [3:0]        i_raddr0,
  input  logic [3:0]        i_raddr1,
  input  logic [3:0]        i_raddr2,
  output logic [DATA_W-1:0] o_rdata0,
  output logic [DATA_W-1:0] o_rdata1,
  output logic [DATA_W-1:0] o_rdata2
);

  logic [DATA_W-1:0] r_regs [16];

  // Array update: clear everything on reset, otherwise write one entry when enabled
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      for (int i = 0; i < 16; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata0 = r_regs[i_raddr0];
  assign o_rdata1 = r_regs[i_raddr1];
  assign o_rdata2 = r_regs[i_raddr2];

endmodule

// File: rtl/writeback_regfile.sv
// rtl/writeback_regfile.sv - writeback stage: register/PSR commit, bypassed reads, r15 redirect; optional WB_PERFCNT_EN retire counter
module writeback_regfile
  import writeback_regfile_pkg::*;
#(
  parameter int         DATA_W    = 32,
  parameter logic [3:0] PC_REG    = PC_REG_NUM,
  parameter int         PERFCNT_W = 32
) (
  input  logic                 clk,
  input  logic                 Nrst,
  writeback_regfile_if.slave   wb,
  output logic [DATA_W-1:0]    cpsr,
  output logic [DATA_W-1:0]    spsr,
  output logic                 jmp,
`ifdef WB_PERFCNT_EN
  output logic [DATA_W-1:0]    jmppc,
  output logic [PERFCNT_W-1:0] retired
`else
  output logic [DATA_W-1:0]    jmppc
`endif
);

  logic              w_commit;
  logic              w_wen;
  logic              w_pc_write;
  logic [DATA_W-1:0] w_rf_rd0;
  logic [DATA_W-1:0] w_rf_rd1;
  logic [DATA_W-1:0] w_rf_rd2;

  logic [DATA_W-1:0] r_cpsr;
  logic [DATA_W-1:0] r_spsr;
  logic              r_jmp;
  logic [DATA_W-1:0] r_jmppc;

  // A bundle commits only when it is real and the pipeline is moving; a
  // stalled bundle is presented again, so it must not act until released.
  assign w_commit   = !wb.stall && !wb.inbubble;
  assign w_wen      = w_commit && wb.write_reg;
  assign w_pc_write = w_wen && (wb.write_num == PC_REG);

  regfile_16x32 #(
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk      (clk),
    .Nrst     (Nrst),
    .i_we     (w_wen),
    .i_waddr  (wb.write_num),
    .i_wdata  (wb.write_data),
    .i_raddr0 (wb.rd0_num),
    .i_raddr1 (wb.rd1_num),
    .i_raddr2 (wb.rd2_num),
    .o_rdata0 (w_rf_rd0),
    .o_rdata1 (w_rf_rd1),
    .o_rdata2 (w_rf_rd2)
  );

  // Same-cycle bypass: a committing write wins over the stored value,
  // r15 included (Issue applies the pipeline offset on its side).
  assign wb.rd0_data = (w_wen && (wb.write_num == wb.rd0_num)) ? wb.write_data : w_rf_rd0;
  assign wb.rd1_data = (w_wen && (wb.write_num == wb.rd1_num)) ? wb.write_data : w_rf_rd1;
  assign wb.rd2_data = (w_wen && (wb.write_num == wb.rd2_num)) ? wb.write_data : w_rf_rd2;

  // PSR commit: take Execute's values on every commit, hold otherwise
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_cpsr <= DATA_W'(CPSR_RESET);
      r_spsr <= '0;
    end else if (w_commit) begin
      r_cpsr <= wb.incpsr;
      r_spsr <= wb.inspsr;
    end
  end

  // Redirect: one-cycle pulse per committed r15 write, target word-aligned
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_jmp   <= 1'b0;
      r_jmppc <= '0;
    end else begin
      r_jmp <= w_pc_write;
      if (w_pc_write) begin
        r_jmppc <= wb.write_data & ~DATA_W'(3);
      end
    end
  end

  assign cpsr  = r_cpsr;
  assign spsr  = r_spsr;
  assign jmp   = r_jmp;
  assign jmppc = r_jmppc;

`ifdef WB_PERFCNT_EN
  logic [PERFCNT_W-1:0] r_retired;

  // Retire counter: one per committed bundle, wraps naturally
  always_ff @(posedge clk or negedge Nrst) begin
    if (!Nrst) begin
      r_retired <= '0;
    end else if (w_commit) begin
      r_retired <= r_retired + PERFCNT_W'(1);
    end
  end

  assign retired = r_retired;
`else
  localparam int p_unused_perfcnt_w = PERFCNT_W;
`endif

endmodule

// File: tb/tb_writeback_regfile.sv
// tb/tb_writeback_regfile.sv - self-checking bench for writeback_regfile (honours WB_PERFCNT_EN)
module tb_writeback_regfile;

  localparam int DW  = 32;
  localparam int PCW = 4;

  logic clk = 1'b0;
  logic Nrst;
  always #5 clk = ~clk;

  writeback_regfile_if #(.DATA_W(DW)) wb ();

  logic [DW-1:0] cpsr;
  logic [DW-1:0] spsr;
  logic          jmp;
  logic [DW-1:0] jmppc;
`ifdef WB_PERFCNT_EN
  logic [PCW-1:0] retired;
`endif

  writeback_regfile #(
    .DATA_W    (DW),
    .PC_REG    (4'd15),
    .PERFCNT_W (PCW)
  ) dut (
    .clk     (clk),
    .Nrst    (Nrst),
    .wb      (wb),
    .cpsr    (cpsr),
    .spsr    (spsr),
    .jmp     (jmp),
`ifdef WB_PERFCNT_EN
    .jmppc   (jmppc),
    .retired (retired)
`else
    .jmppc   (jmppc)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state as the rules describe it
  logic [31:0] m_regs [16];
  logic [31:0] m_cpsr;
  logic [31:0] m_spsr;
  logic        m_jmp;
  logic [31:0] m_jmppc;
  int unsigned m_retired;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    m_cpsr    = 32'h000000D3;
    m_spsr    = 32'h0;
    m_jmp     = 1'b0;
    m_jmppc   = 32'h0;
    m_retired = 0;
  endtask

  task automatic set_idle();
    wb.stall      = 1'b0;
    wb.inbubble   = 1'b1;
    wb.write_reg  = 1'b0;
    wb.write_num  = 4'd0;
    wb.write_data = 32'h0;
    wb.incpsr     = 32'h0;
    wb.inspsr     = 32'h0;
  endtask

  task automatic drive(input logic st, input logic bub, input logic wr, input logic [3:0] num,
                       input logic [31:0] data, input logic [31:0] cp, input logic [31:0] sp);
    wb.stall      = st;
    wb.inbubble   = bub;
    wb.write_reg  = wr;
    wb.write_num  = num;
    wb.write_data = data;
    wb.incpsr     = cp;
    wb.inspsr     = sp;
  endtask

  function automatic logic [31:0] exp_rd(input logic [3:0] num);
    if (!wb.stall && !wb.inbubble && wb.write_reg && wb.write_num == num) return wb.write_data;
    return m_regs[num];
  endfunction

  task automatic check_reads(input string tag);
    check({tag, ".rd0"}, wb.rd0_data, exp_rd(wb.rd0_num));
    check({tag, ".rd1"}, wb.rd1_data, exp_rd(wb.rd1_num));
    check({tag, ".rd2"}, wb.rd2_data, exp_rd(wb.rd2_num));
  endtask

  // Read back all 16 registers in six sub-steps (fits inside one cycle)
  task automatic check_all(input string tag);
    for (int i = 0; i < 6; i++) begin
      wb.rd0_num = 4'((3 * i) % 16);
      wb.rd1_num = 4'((3 * i + 1) % 16);
      wb.rd2_num = 4'((3 * i + 2) % 16);
      #1;
      check_reads(tag);
    end
  endtask

  // One clock: advance the model from the presented bundle, then check outputs
  task automatic step(input string tag);
    logic c, w;
    c = !wb.stall && !wb.inbubble;
    w = c && wb.write_reg;
    @(posedge clk);
    m_jmp = w && (wb.write_num == 4'd15);
    if (m_jmp) m_jmppc = {wb.write_data[31:2], 2'b00};
    if (w) m_regs[wb.write_num] = wb.write_data;
    if (c) begin
      m_cpsr = wb.incpsr;
      m_spsr = wb.inspsr;
      m_retired++;
    end
    #1;
    check({tag, ".jmp"}, {31'b0, jmp}, {31'b0, m_jmp});
    if (m_jmp) check({tag, ".jmppc"}, jmppc, m_jmppc);
    check({tag, ".cpsr"}, cpsr, m_cpsr);
    check({tag, ".spsr"}, spsr, m_spsr);
`ifdef WB_PERFCNT_EN
    check({tag, ".retired"}, {28'b0, retired}, m_retired % (1 << PCW));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] saved_cpsr;
    int          pick;

    // Reset state
    Nrst = 1'b0;
    set_idle();
    wb.rd0_num = 0; wb.rd1_num = 0; wb.rd2_num = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    Nrst = 1'b1;
    check("reset.cpsr", cpsr, 32'h000000D3);
    check("reset.spsr", spsr, 32'h0);
    check("reset.jmp", {31'b0, jmp}, 32'h0);
    check("reset.jmppc", jmppc, 32'h0);
`ifdef WB_PERFCNT_EN
    check("reset.retired", {28'b0, retired}, 32'h0);
`endif
    check_all("reset.regs");

    // Write r3 with same-cycle bypass, then from the array
    step("idle0");
    drive(0, 0, 1, 4'd3, 32'hDEADBEEF, 32'h000000D3, 32'h0);
    wb.rd0_num = 4'd3;
    #1;
    check("t2.bypass", wb.rd0_data, 32'hDEADBEEF);
    step("t2.commit");
    set_idle();
    #1;
    check("t2.array", wb.rd0_data, 32'hDEADBEEF);

    // Stall for 3 cycles holds the write back, then exactly one commit
    drive(1, 0, 1, 4'd3, 32'h12345678, 32'h600000D3, 32'h11);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3.held", wb.rd0_data, 32'hDEADBEEF);
      step("t3.stall");
    end
    wb.stall = 1'b0;
    #1;
    check("t3.release_bypass", wb.rd0_data, 32'h12345678);
    step("t3.release");
    set_idle();
    #1;
    check("t3.after", wb.rd0_data, 32'h12345678);
    check("t3.cpsr", cpsr, 32'h600000D3);

    // r15 write redirects once, word-aligned
    drive(0, 0, 1, 4'd15, 32'h00001006, m_cpsr, m_spsr);
    step("t4.commit");
    check("t4.jmp", {31'b0, jmp}, 32'h1);
    check("t4.jmppc", jmppc, 32'h00001004);
    set_idle();
    step("t4.after");
    check("t4.jmp_low", {31'b0, jmp}, 32'h0);

    // Stalled r15 bundle redirects only when it finally commits
    drive(1, 0, 1, 4'd15, 32'h0000200B, m_cpsr, m_spsr);
    step("t4s.stall0");
    step("t4s.stall1");
    check("t4s.no_jmp", {31'b0, jmp}, 32'h0);
    wb.stall = 1'b0;
    step("t4s.commit");
    check("t4s.jmppc", jmppc, 32'h00002008);
    set_idle();
    step("t4s.after");

    // Bubble carrying a write: nothing changes
    saved_cpsr = m_cpsr;
    drive(0, 1, 1, 4'd5, 32'hAAAA5555, 32'hF00000D3, 32'h1F);
    wb.rd0_num = 4'd5;
    #1;
    check("t5.no_bypass", wb.rd0_data, 32'h0);
    step("t5.bubble");
    check("t5.cpsr", cpsr, saved_cpsr);
    check("t5.jmp", {31'b0, jmp}, 32'h0);
    check_all("t5.regs");

    // Undriven write fields while not writing must not corrupt state
    drive(0, 0, 0, 4'bxxxx, 32'hxxxxxxxx, 32'h100000D3, 32'h2);
    step("tx.nowrite");
    drive(1, 0, 1, 4'bxxxx, 32'hxxxxxxxx, 32'hxxxxxxxx, 32'hxxxxxxxx);
    step("tx.stalled");
    set_idle();
    check_all("tx.regs");

    // Reset during a redirect pulse discards everything
    drive(0, 0, 1, 4'd15, 32'h00003000, 32'h200000D3, 32'h3);
    step("rst.pre");
    set_idle();
    #2;
    Nrst = 1'b0;
    #1;
    model_reset();
    check("rst.jmp", {31'b0, jmp}, 32'h0);
    check("rst.jmppc", jmppc, 32'h0);
    check("rst.cpsr", cpsr, 32'h000000D3);
    @(posedge clk);
    #1;
    Nrst = 1'b1;
    check_all("rst.regs");

    // 10 commits, 4 bubbles, 2 stalled cycles; then 8 more commits to wrap
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 1) drive(0, 1, 1, 4'(i), 32'(i * 7), 32'h0, 32'h0);
      else if (i == 6 || i == 10) drive(1, 0, 1, 4'(i), 32'(i * 11), 32'h0, 32'h0);
      else drive(0, 0, 1, 4'(i % 15), 32'(i * 13), 32'h000000D3, 32'(i));
      step("t6.mix");
    end
`ifdef WB_PERFCNT_EN
    check("t6.retired10", {28'b0, retired}, 32'd10);
`endif
    for (int i = 0; i < 8; i++) begin
      drive(0, 0, 0, 4'd0, 32'h0, 32'h000000D3, 32'h0);
      step("t6.more");
    end
`ifdef WB_PERFCNT_EN
    check("t6.wrap", {28'b0, retired}, 32'd2);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) != 0,
            ($urandom_range(0, 5) == 0) ? 4'd15 : 4'($urandom), $urandom, $urandom, $urandom);
      pick = $urandom_range(0, 4);
      wb.rd0_num = (pick == 0) ? wb.write_num : 4'($urandom);
      wb.rd1_num = (pick == 1) ? wb.write_num : 4'($urandom);
      wb.rd2_num = (pick == 2) ? wb.rd0_num : 4'($urandom);
      if (pick == 3) begin
        wb.rd1_num = wb.rd0_num;
        wb.rd2_num = wb.rd0_num;
      end
      #1;
      check_reads("rand");
      step("rand");
    end
    set_idle();
    step("final");
    check_all("final.regs");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
